// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_responder_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous word RAM with per-byte write enables, no reset.
// Latency: write lands at the enabling edge; read data registered one cycle after.
// Backpressure: none; rdata holds until the next enabled read.
module dmem_sram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    input  logic [BE_W-1:0]  be,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store against a local SRAM.
// Latency: store/error response 1 cycle after acceptance, load response 2 cycles.
// Backpressure: response held until rsp_ready; req_ready low while busy.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int                IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

    state_t           state;
    state_t           state_nxt;
    logic             req_fire;
    logic             addr_err;
    logic             sram_en;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      sram_rdata;

    assign req_ready = reset && (state == IDLE);
    assign req_fire  = req_valid && req_ready;

    // Range check uses the full word index so out-of-range addresses never alias.
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:2] >= DEPTH_LIM);
    assign word_idx = req_addr[IDX_W+1:2];
    assign sram_en  = req_fire && !addr_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_nxt = (req_we || addr_err) ? RESP : READ;
                end
            end
            READ:    state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire && (req_we || addr_err)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= addr_err;
                        rsp_rdata <= '0;
                    end
                end
                READ: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= sram_rdata;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (req_we),
        .addr  (word_idx),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] b_addr [3] = '{32'h20, 32'h24, 32'h28};
    logic [31:0] b_exp  [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .ADDR_W      (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with rsp_ready held high, checking exact latency.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic exp_err, input logic [31:0] exp_rd);
        int n;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_acc"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        if (!we && !exp_err) begin
            chk({tag, "_lat"}, 32'(rsp_valid), 32'd0);
            tick();
        end
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_rd"}, rsp_rdata, exp_rd);
        tick();
        chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int rsp;
        int last_acc;
        logic fire;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        reset = 1'b1;
        #1;

        // First request is taken on the very first edge after release.
        txn("st0", 1'b1, 32'h0, 32'h0123_4567, 4'hF, 1'b0, 32'h0);
        txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);

        txn("ld13_err", 1'b0, 32'h13, 32'h0, 4'hF, 1'b1, 32'h0);
        txn("ld1000_err", 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 32'h0);
        txn("st1000_err", 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
        txn("st12_err", 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
        txn("ld0_noalias", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0123_4567);
        txn("ld10_unchg", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);

        txn("stFFC", 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
        txn("ldFFC", 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D);

        // Reset asserted while a load sits in READ.
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        chk("rstrd_valid", 32'(rsp_valid), 32'd0);
        chk("rstrd_err", 32'(rsp_err), 32'd0);
        chk("rstrd_rdata", rsp_rdata, 32'd0);
        chk("rstrd_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstrd_norsp", 32'(rsp_valid), 32'd0);
        end
        txn("ld10_postrst", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);

        txn("st10_b0", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0);
        txn("ld10_b0", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEAA);
        txn("st10_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0);
        txn("ld10_be0", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEAA);

        // Response held under backpressure for 5 cycles.
        rsp_ready = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hDEAD_BEAA);
            chk("hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("hold_rel_valid", 32'(rsp_valid), 32'd0);
        chk("hold_rel_rdata", rsp_rdata, 32'd0);
        chk("hold_rel_ready", 32'(req_ready), 32'd1);

        txn("st20", 1'b1, 32'h20, 32'h1111_1111, 4'hF, 1'b0, 32'h0);
        txn("st24", 1'b1, 32'h24, 32'h2222_2222, 4'hF, 1'b0, 32'h0);
        txn("st28", 1'b1, 32'h28, 32'h3333_3333, 4'hF, 1'b0, 32'h0);

        // Back-to-back loads with req_valid held high.
        acc       = 0;
        rsp       = 0;
        last_acc  = -1;
        req_we    = 1'b0;
        req_be    = 4'h0;
        rsp_ready = 1'b1;
        req_addr  = b_addr[0];
        req_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            fire = req_ready && req_valid;
            if (rsp_valid) begin
                if (rsp < 3) begin
                    chk("b2b_rdata", rsp_rdata, b_exp[rsp]);
                end
                rsp++;
            end
            if (fire) begin
                if (acc > 0) begin
                    chk("b2b_gap", 32'(c - last_acc), 32'd3);
                end
                last_acc = c;
            end
            tick();
            if (fire) begin
                acc++;
                if (acc < 3) begin
                    req_addr = b_addr[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        chk("b2b_acc_cnt", 32'(acc), 32'd3);
        chk("b2b_rsp_cnt", 32'(rsp), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width of req_addr.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have ports req_valid input 1 and req_ready output 1, the request handshake (transfer when both are 1 at a clk edge).
REQ-006 SHALL have ports req_we input 1 (1 = store, 0 = load), req_addr input ADDR_W (byte address), req_wdata input 32 and req_be input 4 (byte enables, bit i = byte i).
REQ-007 SHALL have ports rsp_valid output 1 and rsp_ready input 1, the response handshake.
REQ-008 SHALL have ports rsp_rdata output 32 (load data, 0 for stores/errors) and rsp_err output 1 (request rejected).

Function
REQ-009 SHALL implement FSM states IDLE, READ, RESP.
REQ-010 SHALL drive req_ready=1 only in IDLE while reset is deasserted; exactly one request is outstanding at a time.
REQ-011 SHALL flag error when req_addr[1:0]!=0 or req_addr[ADDR_W-1:2] >= DEPTH_WORDS; error requests SHALL NOT access memory.
REQ-012 Accepted error request (edge N): SHALL go IDLE->RESP with rsp_valid=1, rsp_err=1, rsp_rdata=0 from cycle N+1.
REQ-013 Accepted valid store (edge N): SHALL write bytes with req_be=1 at edge N, leave other bytes unchanged, go IDLE->RESP, rsp_valid=1, rsp_err=0, rsp_rdata=0 from cycle N+1.
REQ-014 Store with req_be=4'b0000 SHALL complete normally (ack) with no memory change.
REQ-015 Accepted valid load (edge N): SHALL present the word address to the SRAM at edge N, go IDLE->READ, then READ->RESP at edge N+1, capturing SRAM data into rsp_rdata; rsp_valid=1 from cycle N+2; req_be is ignored for loads.
REQ-016 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1 at an edge; at that edge SHALL return to IDLE and clear rsp_valid, rsp_err and rsp_rdata to 0.
REQ-017 Load immediately following a store to the same word SHALL return the post-store data (write completes before the next read is issued).
REQ-018 req_valid while req_ready=0 SHALL be ignored; requester holds it.
REQ-019 Word index SHALL be req_addr[ADDR_W-1:2] truncated to clog2(DEPTH_WORDS) bits only after the range check passes; no wrap-around aliasing.
REQ-020 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-021 While reset=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, taking effect asynchronously.
REQ-022 Reset asserted in READ or RESP SHALL abandon the transaction with no response delivered after reset release.
REQ-023 A store accepted at an edge before reset assertion remains written; no store SHALL occur while reset=0.
REQ-024 SRAM contents SHALL NOT be cleared by reset.
REQ-025 First request SHALL be acceptable on the first clk edge after reset rises.

Structure
REQ-026 Shared package SHALL hold the state enum (IDLE, READ, RESP) and constants WORD_BYTES=4, BE_W=4.
REQ-027 Storage SHALL be one sub-module dmem_sram: single-port synchronous RAM, DEPTH_WORDS x 32, per-byte write enable, 1-cycle registered read, no reset.
REQ-028 dmem_responder SHALL contain only FSM, address check, response registers and dmem_sram instance.

Verification
REQ-029 Store addr 0x10, wdata 0xDEADBEEF, be 4'hF; then load 0x10 -> store ack at N+1 (err=0, rdata=0); load rsp_rdata=0xDEADBEEF at N+2 after its acceptance.
REQ-030 Store 0x10 wdata 0x000000AA be 4'b0001 over 0xDEADBEEF, load 0x10 -> rsp_rdata=0xDEADBEAA.
REQ-031 Load 0x13 (misaligned) and load 0x1000 with DEPTH_WORDS=1024 -> each rsp_err=1, rsp_rdata=0 at N+1; memory unchanged.
REQ-032 Load 0x10 with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata constant, req_ready=0 throughout; return to IDLE on the edge where rsp_ready=1.
REQ-033 Reset=0 asserted in READ -> outputs zero immediately; after release no rsp_valid until a new request; prior stored 0xDEADBEEF still readable.
REQ-034 Back-to-back: req_valid held high with 3 loads, rsp_ready=1 -> one acceptance per 3 cycles, responses in order.
